// File: rtl/ram_hs.sv
// Single-port word RAM with a four-phase rq/ack handshake and per-byte write enables.
// Optional per-lane even parity with write-side error injection: define RAM_HS_PARITY_EN.
module ram_hs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DELAY_ACK  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rq,
   input  logic                    wr_ni,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   dataW,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic                    err_inj,
   output logic                    ack,
   output logic                    busy,
   output logic [DATA_WIDTH-1:0]   dataR,
   output logic                    perr
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                  r_state, w_next;
   logic [3:0]              r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_rd;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [NB-1:0]           r_be;
   logic                    r_ack;
   logic [DATA_WIDTH-1:0]   r_dataR;
   logic                    r_perr;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic                    w_capture, w_access, w_ack_clr, w_perr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (rq) w_next = S_WAIT;
         S_WAIT: begin
            if (!rq)                         w_next = S_IDLE;
            else if (r_cnt == 4'(DELAY_ACK)) w_next = S_ACK;
         end
         S_ACK:  if (!rq) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_capture = (r_state == S_IDLE) && rq;
      w_access  = (r_state == S_WAIT) && rq && (r_cnt == 4'(DELAY_ACK));
      w_ack_clr = (r_state == S_ACK) && !rq;
      busy      = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_rd    <= 1'b0;
         r_data  <= '0;
         r_be    <= '0;
         r_ack   <= 1'b0;
         r_dataR <= '0;
         r_perr  <= 1'b0;
      end else begin
         if (w_capture) begin
            r_cnt  <= '0;
            r_addr <= address;
            r_rd   <= wr_ni;
            r_data <= dataW;
            r_be   <= be;
         end else if (r_state == S_WAIT && !w_access) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (w_access) begin
            r_ack <= 1'b1;
            if (r_rd) begin
               r_dataR <= r_mem[r_addr];
               r_perr  <= w_perr;
            end
         end else if (w_ack_clr) begin
            r_ack <= 1'b0;
         end
      end
   end

   // Storage is deliberately not reset; only a completed write access touches it.
   always_ff @(posedge clk) begin
      if (w_access && !r_rd)
         for (int i = 0; i < NB; i++)
            if (r_be[i]) r_mem[r_addr][8*i +: 8] <= r_data[8*i +: 8];
   end

`ifdef RAM_HS_PARITY_EN
   logic          r_inj;
   logic [NB-1:0] r_par [DEPTH];
   logic [NB-1:0] w_par_mis;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_inj <= 1'b0;
      else if (w_capture) r_inj <= err_inj;
   end

   always_ff @(posedge clk) begin
      if (w_access && !r_rd)
         for (int i = 0; i < NB; i++)
            if (r_be[i]) r_par[r_addr][i] <= (^r_data[8*i +: 8]) ^ r_inj;
   end

   always_comb begin
      for (int i = 0; i < NB; i++)
         w_par_mis[i] = (^r_mem[r_addr][8*i +: 8]) ^ r_par[r_addr][i];
      w_perr = |w_par_mis;
   end
`else
   logic w_unused_inj;
   assign w_unused_inj = err_inj;
   assign w_perr       = 1'b0;
`endif

   assign ack   = r_ack;
   assign dataR = r_dataR;
   assign perr  = r_perr;
endmodule

// File: tb/tb_ram_hs.sv
// Bench for ram_hs: directed vector table, hand sequences for abort/reset/zero-delay,
// and random traffic checked against a plain array memory model.
module tb_ram_hs;
   localparam int DLY = 2;
`ifdef RAM_HS_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk = 1'b0, reset = 1'b1;
   logic        rq = 1'b0, wr_ni = 1'b0, err_inj = 1'b0;
   logic [3:0]  address = '0, be = '0;
   logic [31:0] dataW = '0;
   logic        ack, busy, perr;
   logic [31:0] dataR;

   logic        rq0 = 1'b0, wr_ni0 = 1'b0, err_inj0 = 1'b0;
   logic [3:0]  address0 = '0, be0 = '0;
   logic [31:0] dataW0 = '0;
   logic        ack0, busy0, perr0;
   logic [31:0] dataR0;

   int checks = 0, errors = 0;

   logic [31:0] m_mem [16];
   logic [3:0]  m_inj [16];
   logic [31:0] m_rd = '0;

   typedef struct {
      logic        rd;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        inj;
      logic [31:0] exp_d;
      logic        exp_p;
   } vec_t;
   vec_t tbl [12];

   ram_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DELAY_ACK(DLY)) u_dut (
      .clk(clk), .reset(reset), .rq(rq), .wr_ni(wr_ni), .address(address),
      .dataW(dataW), .be(be), .err_inj(err_inj),
      .ack(ack), .busy(busy), .dataR(dataR), .perr(perr));

   ram_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DELAY_ACK(0)) u_dut0 (
      .clk(clk), .reset(reset), .rq(rq0), .wr_ni(wr_ni0), .address(address0),
      .dataW(dataW0), .be(be0), .err_inj(err_inj0),
      .ack(ack0), .busy(busy0), .dataR(dataR0), .perr(perr0));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs changed after capture must not disturb the operation in flight.
   task automatic scramble();
      wr_ni   = 1'($urandom);
      address = 4'($urandom);
      dataW   = $urandom;
      be      = 4'($urandom);
      err_inj = 1'($urandom);
   endtask

   // Called just after a negedge; returns just after a negedge with rq low.
   task automatic op(input logic rd, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic inj, input int abort_at,
                     output logic [31:0] rdv, output logic rp);
      int n;
      bit got;
      logic [31:0] exp;
      rq = 1'b1; wr_ni = rd; address = a; dataW = d; be = b; err_inj = inj;
      rdv = '0; rp = 1'b0;
      if (abort_at >= 0) begin
         for (int k = 0; k <= abort_at; k++) begin
            @(negedge clk);
            scramble();
            chk("abort_noack", 64'(ack), 64'(0));
         end
         rq = 1'b0;
         @(negedge clk);
         chk("abort_ack", 64'(ack), 64'(0));
         chk("abort_busy", 64'(busy), 64'(0));
         chk("abort_dataR", 64'(dataR), 64'(m_rd));
         return;
      end
      n = 0; got = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (ack) got = 1;
         else begin
            chk("wait_busy", 64'(busy), 64'(1));
            scramble();
         end
      end
      chk("ack_latency", got ? 64'(n - 1) : 64'hFFFF, 64'(DLY + 1));
      if (rd) begin
         exp = m_mem[a];
         chk("rd_data", 64'(dataR), 64'(exp));
         chk("rd_perr", 64'(perr), 64'(PAR && (m_inj[a] != 4'd0)));
         m_rd = exp;
      end else begin
         for (int l = 0; l < 4; l++)
            if (b[l]) begin
               m_mem[a][8*l +: 8] = d[8*l +: 8];
               m_inj[a][l] = inj;
            end
         chk("wr_keeps_dataR", 64'(dataR), 64'(m_rd));
      end
      rdv = dataR; rp = perr;
      repeat ($urandom_range(0, 2)) begin
         scramble();
         @(negedge clk);
         chk("ack_hold", 64'(ack), 64'(1));
      end
      rq = 1'b0;
      @(negedge clk);
      chk("ack_fall", 64'(ack), 64'(0));
      chk("busy_fall", 64'(busy), 64'(0));
   endtask

   initial begin
      logic [31:0] rdv;
      logic        rp;
      int          ab;

      tbl[0]  = '{1'b0, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0};
      tbl[1]  = '{1'b1, 4'd3, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b0, 4'd5, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0};
      tbl[3]  = '{1'b0, 4'd5, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0, 1'b0};
      tbl[4]  = '{1'b1, 4'd5, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 1'b0};
      tbl[5]  = '{1'b0, 4'd1, 32'h00000055, 4'hF, 1'b1, 32'h0, 1'b0};
      tbl[6]  = '{1'b1, 4'd1, 32'h0,        4'h0, 1'b0, 32'h00000055, PAR};
      tbl[7]  = '{1'b0, 4'd1, 32'h00000055, 4'hF, 1'b0, 32'h0, 1'b0};
      tbl[8]  = '{1'b1, 4'd1, 32'h0,        4'h0, 1'b0, 32'h00000055, 1'b0};
      tbl[9]  = '{1'b0, 4'd4, 32'h12345678, 4'h0, 1'b0, 32'h0, 1'b0};
      tbl[10] = '{1'b1, 4'd4, 32'h0,        4'h0, 1'b0, 32'h00000000, 1'b0};
      tbl[11] = '{1'b1, 4'd15, 32'h0,       4'h0, 1'b0, 32'h00000000, 1'b0};

      #1;
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_dataR", 64'(dataR), 64'(0));
      chk("rst_perr", 64'(perr), 64'(0));
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Zero-delay instance: write then read address 15, rq held 5 cycles.
      rq0 = 1'b1; wr_ni0 = 1'b0; address0 = 4'd15; dataW0 = 32'hCAFE0015; be0 = 4'hF;
      @(negedge clk); chk("d0_wr_ack_early", 64'(ack0), 64'(0));
      @(negedge clk); chk("d0_wr_ack", 64'(ack0), 64'(1));
      rq0 = 1'b0;
      @(negedge clk); chk("d0_wr_ack_fall", 64'(ack0), 64'(0));
      rq0 = 1'b1; wr_ni0 = 1'b1;
      @(negedge clk);
      chk("d0_rd_ack_early", 64'(ack0), 64'(0));
      chk("d0_rd_busy", 64'(busy0), 64'(1));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("d0_rd_ack_hold", 64'(ack0), 64'(1));
         if (c == 0) begin
            chk("d0_rd_data", 64'(dataR0), 64'(32'hCAFE0015));
            chk("d0_rd_perr", 64'(perr0), 64'(0));
         end
      end
      rq0 = 1'b0;
      @(negedge clk);
      chk("d0_rd_ack_fall", 64'(ack0), 64'(0));
      chk("d0_rd_busy_fall", 64'(busy0), 64'(0));

      for (int i = 0; i < 16; i++) op(1'b0, 4'(i), 32'h0, 4'hF, 1'b0, -1, rdv, rp);

      for (int i = 0; i < 12; i++) begin
         op(tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].inj, -1, rdv, rp);
         if (tbl[i].rd) begin
            chk("tbl_data", 64'(rdv), 64'(tbl[i].exp_d));
            chk("tbl_perr", 64'(rp), 64'(tbl[i].exp_p));
         end
      end

      // Aborted write to address 2 after one WAIT cycle.
      op(1'b0, 4'd2, 32'hFFFFFFFF, 4'hF, 1'b0, 0, rdv, rp);
      op(1'b1, 4'd2, 32'h0, 4'h0, 1'b0, -1, rdv, rp);
      chk("abort_readback", 64'(rdv), 64'(32'h0));

      // Reset during WAIT of a write to address 7.
      op(1'b0, 4'd7, 32'hA5A5A5A5, 4'hF, 1'b0, -1, rdv, rp);
      op(1'b1, 4'd7, 32'h0, 4'h0, 1'b0, -1, rdv, rp);
      rq = 1'b1; wr_ni = 1'b0; address = 4'd7; dataW = 32'h12345678; be = 4'hF;
      @(negedge clk);
      chk("rstw_busy_before", 64'(busy), 64'(1));
      #2 reset = 1'b1;
      #1;
      chk("rstw_ack", 64'(ack), 64'(0));
      chk("rstw_busy", 64'(busy), 64'(0));
      chk("rstw_dataR", 64'(dataR), 64'(0));
      @(negedge clk);
      reset = 1'b0; rq = 1'b0; m_rd = '0;
      @(negedge clk);
      op(1'b1, 4'd7, 32'h0, 4'h0, 1'b0, -1, rdv, rp);
      chk("rstw_readback", 64'(rdv), 64'(32'hA5A5A5A5));

      for (int i = 0; i < 150; i++) begin
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DLY)) : -1;
         op(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 1'($urandom), ab, rdv, rp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
